// File: rtl/reorder_buffer_mc.sv
// Multi-commit reorder buffer: in-order dispatch, out-of-order CDB completion and
// in-order retirement of up to N_COMMIT entries per cycle, halting at a faulting entry.
module reorder_buffer_mc #(
   parameter int DEPTH_W    = 4,
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 6,
   parameter int INSTR_W    = 32,
   parameter int N_RD       = 6,
   parameter int N_COMMIT   = 2
) (
   input  logic                                 clk,
   input  logic                                 nrst,
   input  logic                                 i_valid,
   output logic                                 i_ready,
   output logic [DEPTH_W-1:0]                   i_rob_id,
   input  logic [REG_ADDR_W-1:0]                i_dst_reg,
   input  logic [INSTR_W-1:0]                   i_opcode,
   input  logic                                 i_no_wait,
   input  logic [N_RD-1:0][DEPTH_W-1:0]         rd_id,
   output logic [N_RD-1:0][DATA_W-1:0]          rd_data,
   output logic [N_RD-1:0]                      rd_filled,
   input  logic                                 cdb_valid,
   input  logic [DEPTH_W-1:0]                   cdb_id,
   input  logic [DATA_W-1:0]                    cdb_data,
   input  logic                                 cdb_exception,
   input  logic                                 flush,
   output logic [N_COMMIT-1:0]                  o_valid,
   input  logic [N_COMMIT-1:0]                  o_ready,
   output logic [N_COMMIT-1:0][DEPTH_W-1:0]     o_rob_id,
   output logic [N_COMMIT-1:0][REG_ADDR_W-1:0]  o_dst_reg,
   output logic [N_COMMIT-1:0][INSTR_W-1:0]     o_opcode,
   output logic [N_COMMIT-1:0][DATA_W-1:0]      o_data,
   output logic [N_COMMIT-1:0]                  o_exception,
   output logic [DEPTH_W:0]                     count,
   output logic                                 empty,
   output logic                                 full
);

   localparam int DEPTH = 2 ** DEPTH_W;
   localparam int RC_W  = 3;

   logic [DEPTH-1:0]      ent_valid;
   logic [DEPTH-1:0]      ent_ready;
   logic [DEPTH-1:0]      ent_exc;
   logic [REG_ADDR_W-1:0] ent_dst  [DEPTH];
   logic [INSTR_W-1:0]    ent_op   [DEPTH];
   logic [DATA_W-1:0]     ent_data [DEPTH];

   logic [DEPTH_W-1:0]                head;
   logic [DEPTH_W-1:0]                tail;
   logic                              dispatch;
   logic [N_COMMIT-1:0][DEPTH_W-1:0]  lane_idx;
   logic [N_COMMIT-1:0]               retire_mask;
   logic [RC_W-1:0]                   retire_cnt;

   // i_ready looks only at the registered count, so a retirement never frees a slot the same cycle
   assign full     = (count == (DEPTH_W+1)'(DEPTH));
   assign empty    = (count == '0);
   assign i_ready  = !full && !flush;
   assign dispatch = i_valid && i_ready;
   assign i_rob_id = tail;

   always_comb begin
      logic chain_ok;
      logic chain_exc;
      logic run;
      o_valid     = '0;
      o_rob_id    = '0;
      o_dst_reg   = '0;
      o_opcode    = '0;
      o_data      = '0;
      o_exception = '0;
      lane_idx    = '0;
      retire_mask = '0;
      retire_cnt  = '0;
      chain_ok    = 1'b1;
      chain_exc   = 1'b0;
      run         = 1'b1;
      // A lane is presented only if every earlier lane is presented and none of them faulted
      for (int k = 0; k < N_COMMIT; k++) begin
         lane_idx[k] = head + DEPTH_W'(k);
         o_valid[k]  = !flush && chain_ok && !chain_exc &&
                       ent_valid[lane_idx[k]] && ent_ready[lane_idx[k]];
         if (o_valid[k]) begin
            o_rob_id[k]    = lane_idx[k];
            o_dst_reg[k]   = ent_dst[lane_idx[k]];
            o_opcode[k]    = ent_op[lane_idx[k]];
            o_data[k]      = ent_data[lane_idx[k]];
            o_exception[k] = ent_exc[lane_idx[k]];
         end
         chain_ok  = o_valid[k];
         chain_exc = ent_exc[lane_idx[k]];
         if (run && o_valid[k] && o_ready[k]) begin
            retire_mask[k] = 1'b1;
            retire_cnt     = retire_cnt + RC_W'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   // Read ports see a same-cycle CDB result for their entry before it is stored
   always_comb begin
      rd_data   = '0;
      rd_filled = '0;
      for (int i = 0; i < N_RD; i++) begin
         if (ent_valid[rd_id[i]]) begin
            if (cdb_valid && (cdb_id == rd_id[i])) begin
               rd_data[i]   = cdb_data;
               rd_filled[i] = 1'b1;
            end else begin
               rd_data[i]   = ent_data[rd_id[i]];
               rd_filled[i] = ent_ready[rd_id[i]];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
         ent_ready <= '0;
         ent_exc   <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            ent_dst[e]  <= '0;
            ent_op[e]   <= '0;
            ent_data[e] <= '0;
         end
      end else if (flush) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
         ent_ready <= '0;
         ent_exc   <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            ent_dst[e]  <= '0;
            ent_op[e]   <= '0;
            ent_data[e] <= '0;
         end
      end else begin
         if (cdb_valid && ent_valid[cdb_id]) begin
            ent_ready[cdb_id] <= 1'b1;
            ent_exc[cdb_id]   <= cdb_exception;
            ent_data[cdb_id]  <= cdb_data;
         end
         for (int k = 0; k < N_COMMIT; k++) begin
            if (retire_mask[k]) begin
               ent_valid[lane_idx[k]] <= 1'b0;
               ent_ready[lane_idx[k]] <= 1'b0;
               ent_exc[lane_idx[k]]   <= 1'b0;
               ent_dst[lane_idx[k]]   <= '0;
               ent_op[lane_idx[k]]    <= '0;
               ent_data[lane_idx[k]]  <= '0;
            end
         end
         // The tail entry is never valid while a dispatch is accepted, so it cannot collide
         if (dispatch) begin
            ent_valid[tail] <= 1'b1;
            ent_ready[tail] <= i_no_wait;
            ent_exc[tail]   <= 1'b0;
            ent_dst[tail]   <= i_dst_reg;
            ent_op[tail]    <= i_opcode;
            ent_data[tail]  <= '0;
         end
         head  <= head + DEPTH_W'(retire_cnt);
         tail  <= tail + DEPTH_W'(dispatch);
         count <= count + (DEPTH_W+1)'(dispatch) - (DEPTH_W+1)'(retire_cnt);
      end
   end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Scenario bench for reorder_buffer_mc: expected retirements are queued at dispatch,
// patched on CDB writes and compared when commit lanes are accepted.
module tb_reorder_buffer_mc;

   localparam int DEPTH_W    = 4;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 6;
   localparam int INSTR_W    = 32;
   localparam int N_RD       = 6;
   localparam int N_COMMIT   = 2;

   logic                                clk;
   logic                                nrst;
   logic                                i_valid;
   logic                                i_ready;
   logic [DEPTH_W-1:0]                  i_rob_id;
   logic [REG_ADDR_W-1:0]               i_dst_reg;
   logic [INSTR_W-1:0]                  i_opcode;
   logic                                i_no_wait;
   logic [N_RD-1:0][DEPTH_W-1:0]        rd_id;
   logic [N_RD-1:0][DATA_W-1:0]         rd_data;
   logic [N_RD-1:0]                     rd_filled;
   logic                                cdb_valid;
   logic [DEPTH_W-1:0]                  cdb_id;
   logic [DATA_W-1:0]                   cdb_data;
   logic                                cdb_exception;
   logic                                flush;
   logic [N_COMMIT-1:0]                 o_valid;
   logic [N_COMMIT-1:0]                 o_ready;
   logic [N_COMMIT-1:0][DEPTH_W-1:0]    o_rob_id;
   logic [N_COMMIT-1:0][REG_ADDR_W-1:0] o_dst_reg;
   logic [N_COMMIT-1:0][INSTR_W-1:0]    o_opcode;
   logic [N_COMMIT-1:0][DATA_W-1:0]     o_data;
   logic [N_COMMIT-1:0]                 o_exception;
   logic [DEPTH_W:0]                    count;
   logic                                empty;
   logic                                full;

   reorder_buffer_mc #(
      .DEPTH_W(DEPTH_W), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W),
      .INSTR_W(INSTR_W), .N_RD(N_RD), .N_COMMIT(N_COMMIT)
   ) dut (
      .clk(clk), .nrst(nrst),
      .i_valid(i_valid), .i_ready(i_ready), .i_rob_id(i_rob_id),
      .i_dst_reg(i_dst_reg), .i_opcode(i_opcode), .i_no_wait(i_no_wait),
      .rd_id(rd_id), .rd_data(rd_data), .rd_filled(rd_filled),
      .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data),
      .cdb_exception(cdb_exception), .flush(flush),
      .o_valid(o_valid), .o_ready(o_ready), .o_rob_id(o_rob_id),
      .o_dst_reg(o_dst_reg), .o_opcode(o_opcode), .o_data(o_data),
      .o_exception(o_exception),
      .count(count), .empty(empty), .full(full)
   );

   typedef struct {
      logic [DEPTH_W-1:0]    id;
      logic [REG_ADDR_W-1:0] dst;
      logic [INSTR_W-1:0]    op;
      logic [DATA_W-1:0]     data;
      logic                  exc;
   } exp_t;

   exp_t               sb[$];
   int                 tests_run    = 0;
   int                 tests_failed = 0;
   logic [DEPTH_W-1:0] exp_tail     = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dispatch(input logic [REG_ADDR_W-1:0] dst, input logic [INSTR_W-1:0] op,
                               input logic nw);
      i_valid   = 1'b1;
      i_dst_reg = dst;
      i_opcode  = op;
      i_no_wait = nw;
   endtask

   // Queue the entry the bench expects the current dispatch to create
   task automatic record_dispatch();
      sb.push_back('{exp_tail, i_dst_reg, i_opcode, '0, 1'b0});
      exp_tail = exp_tail + 1'b1;
   endtask

   task automatic drive_cdb(input logic [DEPTH_W-1:0] id, input logic [DATA_W-1:0] d,
                            input logic x);
      cdb_valid     = 1'b1;
      cdb_id        = id;
      cdb_data      = d;
      cdb_exception = x;
      foreach (sb[j]) if (sb[j].id == id) begin
         sb[j].data = d;
         sb[j].exc  = x;
      end
   endtask

   task automatic test_reset();
      #3;
      tests_run++; if (i_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_i_ready: got %b, expected 1", i_ready); end
      tests_run++; if (i_rob_id !== '0) begin tests_failed++; $display("[TB] FAIL reset_i_rob_id: got %0d, expected 0", i_rob_id); end
      tests_run++; if (o_valid !== '0) begin tests_failed++; $display("[TB] FAIL reset_o_valid: got %b, expected 00", o_valid); end
      tests_run++; if ({o_rob_id, o_dst_reg, o_opcode, o_data, o_exception} !== '0) begin tests_failed++; $display("[TB] FAIL reset_commit_fields: got rob_id %h data %h, expected all zero", o_rob_id, o_data); end
      tests_run++; if (rd_filled !== '0 || rd_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_read_ports: got filled %b data %h, expected zero", rd_filled, rd_data); end
      tests_run++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_occupancy: got count %0d empty %b full %b, expected 0 1 0", count, empty, full); end
      @(negedge clk);
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_dispatch();
      o_ready = '0;
      for (int i = 0; i < 3; i++) begin
         set_dispatch(REG_ADDR_W'(i + 1), INSTR_W'(32'hA0 + i), 1'b0);
         #2;
         tests_run++; if (i_rob_id !== exp_tail || i_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL dispatch_id: got id %0d ready %b, expected id %0d ready 1", i_rob_id, i_ready, exp_tail); end
         record_dispatch();
         tick();
      end
      i_valid  = 1'b0;
      rd_id[0] = 4'd1;
      #2;
      tests_run++; if (count !== 5'd3) begin tests_failed++; $display("[TB] FAIL dispatch_count: got %0d, expected 3", count); end
      tests_run++; if (o_valid !== 2'b00) begin tests_failed++; $display("[TB] FAIL dispatch_o_valid: got %b, expected 00", o_valid); end
      tests_run++; if (rd_filled[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL dispatch_not_filled: got %b, expected 0", rd_filled[0]); end
      tick();
   endtask

   task automatic test_ooo_commit();
      exp_t e;
      bit   run;
      logic [N_COMMIT-1:0] exp_ov [4] = '{2'b00, 2'b00, 2'b01, 2'b11};
      logic [DEPTH_W-1:0]  ids    [3] = '{4'd2, 4'd0, 4'd1};
      o_ready = 2'b11;
      for (int c = 0; c < 4; c++) begin
         if (c < 3) drive_cdb(ids[c], 32'h1234_0000 + 32'(ids[c]), 1'b0);
         else cdb_valid = 1'b0;
         #2;
         tests_run++; if (o_valid !== exp_ov[c]) begin tests_failed++; $display("[TB] FAIL ooo_o_valid_c%0d: got %b, expected %b", c, o_valid, exp_ov[c]); end
         run = 1'b1;
         for (int k = 0; k < N_COMMIT; k++) begin
            if (run && o_valid[k] && o_ready[k]) begin
               tests_run++;
               if (sb.size() == 0) begin tests_failed++; $display("[TB] FAIL ooo_lane%0d: got rob_id %0d, expected no entry", k, o_rob_id[k]); end
               else begin
                  e = sb.pop_front();
                  if ({o_rob_id[k], o_dst_reg[k], o_opcode[k], o_data[k], o_exception[k]} !== {e.id, e.dst, e.op, e.data, e.exc}) begin
                     tests_failed++;
                     $display("[TB] FAIL ooo_lane%0d: got id=%0d dst=%h op=%h data=%h exc=%b, expected id=%0d dst=%h op=%h data=%h exc=%b", k, o_rob_id[k], o_dst_reg[k], o_opcode[k], o_data[k], o_exception[k], e.id, e.dst, e.op, e.data, e.exc);
                  end
               end
            end else run = 1'b0;
         end
         tick();
      end
      #2;
      tests_run++; if (empty !== 1'b1 || count !== '0 || sb.size() != 0) begin tests_failed++; $display("[TB] FAIL ooo_drained: got empty %b count %0d pending %0d, expected 1 0 0", empty, count, sb.size()); end
      tick();
   endtask

   task automatic test_fill_wrap();
      exp_t e;
      bit   run;
      flush = 1'b1;
      #2;
      tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_blocks_ready: got %b, expected 0", i_ready); end
      tick();
      flush    = 1'b0;
      sb.delete();
      exp_tail = '0;
      o_ready  = 2'b00;
      for (int i = 0; i < 16; i++) begin
         set_dispatch(REG_ADDR_W'(i), INSTR_W'(32'h100 + i), 1'b1);
         #2;
         tests_run++; if (i_rob_id !== exp_tail || i_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_id: got id %0d ready %b, expected id %0d ready 1", i_rob_id, i_ready, exp_tail); end
         record_dispatch();
         tick();
      end
      set_dispatch(6'h20, 32'h200, 1'b1);
      #2;
      tests_run++; if (full !== 1'b1 || i_ready !== 1'b0 || count !== 5'd16) begin tests_failed++; $display("[TB] FAIL full_state: got full %b ready %b count %0d, expected 1 0 16", full, i_ready, count); end
      o_ready = 2'b01;
      for (int c = 0; c < 14; c++) begin
         if (c == 1) begin
            o_ready = 2'b11;
            #2;
            tests_run++; if (i_ready !== 1'b1 || i_rob_id !== 4'd0) begin tests_failed++; $display("[TB] FAIL wrap_dispatch: got ready %b id %0d, expected ready 1 id 0", i_ready, i_rob_id); end
            record_dispatch();
         end else if (c == 2) begin
            i_valid = 1'b0;
         end
         if (c >= 2 && sb.size() == 0) break;
         #2;
         tests_run++; if (o_valid !== ((sb.size() >= 2) ? 2'b11 : 2'b01)) begin tests_failed++; $display("[TB] FAIL wrap_o_valid_c%0d: got %b, expected %b", c, o_valid, (sb.size() >= 2) ? 2'b11 : 2'b01); end
         run = 1'b1;
         for (int k = 0; k < N_COMMIT; k++) begin
            if (run && o_valid[k] && o_ready[k]) begin
               tests_run++;
               if (sb.size() == 0) begin tests_failed++; $display("[TB] FAIL wrap_lane%0d: got rob_id %0d, expected no entry", k, o_rob_id[k]); end
               else begin
                  e = sb.pop_front();
                  if ({o_rob_id[k], o_dst_reg[k], o_opcode[k], o_data[k], o_exception[k]} !== {e.id, e.dst, e.op, e.data, e.exc}) begin
                     tests_failed++;
                     $display("[TB] FAIL wrap_lane%0d: got id=%0d dst=%h op=%h data=%h exc=%b, expected id=%0d dst=%h op=%h data=%h exc=%b", k, o_rob_id[k], o_dst_reg[k], o_opcode[k], o_data[k], o_exception[k], e.id, e.dst, e.op, e.data, e.exc);
                  end
               end
            end else run = 1'b0;
         end
         tick();
      end
      i_valid = 1'b0;
      #2;
      tests_run++; if (sb.size() != 0 || empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_drained: got pending %0d empty %b, expected 0 1", sb.size(), empty); end
      tick();
   endtask

   task automatic test_exception();
      exp_t e;
      o_ready = 2'b00;
      for (int i = 0; i < 2; i++) begin
         set_dispatch(REG_ADDR_W'(6'h11 + i), INSTR_W'(32'hE0 + i), 1'b0);
         #2;
         tests_run++; if (i_rob_id !== exp_tail) begin tests_failed++; $display("[TB] FAIL exc_dispatch_id: got %0d, expected %0d", i_rob_id, exp_tail); end
         record_dispatch();
         tick();
      end
      i_valid = 1'b0;
      drive_cdb(4'd1, 32'hBAD0_0001, 1'b1);
      tick();
      drive_cdb(4'd2, 32'h0000_0222, 1'b0);
      #2;
      tests_run++; if (o_valid !== 2'b01 || o_exception[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL exc_present: got o_valid %b exc %b, expected 01 1", o_valid, o_exception[0]); end
      tick();
      cdb_valid = 1'b0;
      #2;
      tests_run++; if (o_valid !== 2'b01 || o_rob_id[0] !== 4'd1) begin tests_failed++; $display("[TB] FAIL exc_blocks_lane1: got o_valid %b id %0d, expected 01 1", o_valid, o_rob_id[0]); end
      tick();
      o_ready = 2'b11;
      for (int c = 0; c < 2; c++) begin
         #2;
         tests_run++; if (o_valid !== 2'b01) begin tests_failed++; $display("[TB] FAIL exc_retire_c%0d_o_valid: got %b, expected 01", c, o_valid); end
         tests_run++;
         if (sb.size() == 0) begin tests_failed++; $display("[TB] FAIL exc_lane0_c%0d: got rob_id %0d, expected no entry", c, o_rob_id[0]); end
         else begin
            e = sb.pop_front();
            if ({o_rob_id[0], o_dst_reg[0], o_opcode[0], o_data[0], o_exception[0]} !== {e.id, e.dst, e.op, e.data, e.exc}) begin
               tests_failed++;
               $display("[TB] FAIL exc_lane0_c%0d: got id=%0d data=%h exc=%b, expected id=%0d data=%h exc=%b", c, o_rob_id[0], o_data[0], o_exception[0], e.id, e.data, e.exc);
            end
         end
         tick();
      end
      o_ready = 2'b00;
      #2;
      tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL exc_empty: got %b, expected 1", empty); end
      tick();
   endtask

   task automatic test_read_bypass();
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      sb.delete();
      exp_tail = '0;
      for (int i = 0; i < 6; i++) begin
         set_dispatch(REG_ADDR_W'(i), INSTR_W'(32'h400 + i), 1'b0);
         record_dispatch();
         tick();
      end
      i_valid  = 1'b0;
      rd_id    = '0;
      rd_id[3] = 4'd5;
      rd_id[0] = 4'd4;
      drive_cdb(4'd5, 32'hDEAD_BEEF, 1'b0);
      #2;
      tests_run++; if (rd_data[3] !== 32'hDEAD_BEEF || rd_filled[3] !== 1'b1) begin tests_failed++; $display("[TB] FAIL bypass_same_cycle: got data %h filled %b, expected deadbeef 1", rd_data[3], rd_filled[3]); end
      tests_run++; if (rd_filled[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL bypass_other_id: got filled %b, expected 0", rd_filled[0]); end
      tick();
      rd_id[1] = 4'd7;
      drive_cdb(4'd7, 32'h0000_0077, 1'b0);
      #2;
      tests_run++; if (rd_filled[1] !== 1'b0 || rd_data[1] !== '0) begin tests_failed++; $display("[TB] FAIL bypass_unallocated: got filled %b data %h, expected 0 0", rd_filled[1], rd_data[1]); end
      tests_run++; if (rd_data[3] !== 32'hDEAD_BEEF || rd_filled[3] !== 1'b1) begin tests_failed++; $display("[TB] FAIL stored_result: got data %h filled %b, expected deadbeef 1", rd_data[3], rd_filled[3]); end
      tick();
      cdb_valid = 1'b0;
      #2;
      tests_run++; if (rd_filled[1] !== 1'b0) begin tests_failed++; $display("[TB] FAIL unallocated_stays_empty: got %b, expected 0", rd_filled[1]); end
      tick();
   endtask

   task automatic test_flush();
      o_ready = 2'b00;
      for (int i = 0; i < 4; i++) begin
         set_dispatch(REG_ADDR_W'(i + 8), INSTR_W'(32'h500 + i), 1'b0);
         record_dispatch();
         tick();
      end
      set_dispatch(6'h3F, 32'h5FF, 1'b1);
      flush = 1'b1;
      #2;
      tests_run++; if (count !== 5'd10 || i_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_pre: got count %0d ready %b, expected 10 0", count, i_ready); end
      tick();
      flush   = 1'b0;
      i_valid = 1'b0;
      sb.delete();
      exp_tail = '0;
      #2;
      tests_run++; if (count !== '0 || i_rob_id !== '0 || empty !== 1'b1 || o_valid !== '0) begin tests_failed++; $display("[TB] FAIL flush_post: got count %0d id %0d empty %b o_valid %b, expected 0 0 1 00", count, i_rob_id, empty, o_valid); end
      tick();
   endtask

   task automatic test_async_reset();
      o_ready = 2'b00;
      for (int i = 0; i < 3; i++) begin
         set_dispatch(REG_ADDR_W'(i), INSTR_W'(32'h600 + i), 1'b1);
         record_dispatch();
         tick();
      end
      i_valid  = 1'b0;
      rd_id[0] = 4'd1;
      #2;
      tests_run++; if (count !== 5'd3 || o_valid !== 2'b11 || rd_filled[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_reset: got count %0d o_valid %b filled %b, expected 3 11 1", count, o_valid, rd_filled[0]); end
      nrst = 1'b0;
      #1;
      tests_run++; if (count !== '0 || o_valid !== '0 || i_rob_id !== '0 || rd_filled !== '0 || empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL async_reset: got count %0d o_valid %b id %0d filled %b empty %b, expected 0 00 0 0 1", count, o_valid, i_rob_id, rd_filled, empty); end
      sb.delete();
      exp_tail = '0;
      @(negedge clk);
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit   run;
      logic [N_COMMIT-1:0] exp_ov [4] = '{2'b00, 2'b01, 2'b01, 2'b01};
      logic [DEPTH_W:0]    exp_cnt[4] = '{5'd0, 5'd1, 5'd1, 5'd1};
      o_ready = 2'b11;
      for (int c = 0; c < 4; c++) begin
         if (c < 3) set_dispatch(REG_ADDR_W'(c + 1), INSTR_W'(32'h300 + c), 1'b1);
         else i_valid = 1'b0;
         #2;
         tests_run++; if (o_valid !== exp_ov[c] || count !== exp_cnt[c]) begin tests_failed++; $display("[TB] FAIL b2b_c%0d: got o_valid %b count %0d, expected %b %0d", c, o_valid, count, exp_ov[c], exp_cnt[c]); end
         if (c < 3) begin
            tests_run++; if (i_rob_id !== exp_tail) begin tests_failed++; $display("[TB] FAIL b2b_id_c%0d: got %0d, expected %0d", c, i_rob_id, exp_tail); end
         end
         run = 1'b1;
         for (int k = 0; k < N_COMMIT; k++) begin
            if (run && o_valid[k] && o_ready[k]) begin
               tests_run++;
               if (sb.size() == 0) begin tests_failed++; $display("[TB] FAIL b2b_lane%0d: got rob_id %0d, expected no entry", k, o_rob_id[k]); end
               else begin
                  e = sb.pop_front();
                  if ({o_rob_id[k], o_dst_reg[k], o_opcode[k], o_data[k], o_exception[k]} !== {e.id, e.dst, e.op, e.data, e.exc}) begin
                     tests_failed++;
                     $display("[TB] FAIL b2b_lane%0d: got id=%0d dst=%h op=%h data=%h, expected id=%0d dst=%h op=%h data=%h", k, o_rob_id[k], o_dst_reg[k], o_opcode[k], o_data[k], e.id, e.dst, e.op, e.data);
                  end
               end
            end else run = 1'b0;
         end
         if (c < 3) record_dispatch();
         tick();
      end
      #2;
      tests_run++; if (empty !== 1'b1 || sb.size() != 0) begin tests_failed++; $display("[TB] FAIL b2b_drained: got empty %b pending %0d, expected 1 0", empty, sb.size()); end
      tick();
   endtask

   initial begin
      nrst          = 1'b0;
      i_valid       = 1'b0;
      i_dst_reg     = '0;
      i_opcode      = '0;
      i_no_wait     = 1'b0;
      rd_id         = '0;
      cdb_valid     = 1'b0;
      cdb_id        = '0;
      cdb_data      = '0;
      cdb_exception = 1'b0;
      flush         = 1'b0;
      o_ready       = '0;
      test_reset();
      test_dispatch();
      test_ooo_commit();
      test_fill_wrap();
      test_exception();
      test_read_bypass();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
